// File: rtl/vj_sched_pkg.sv
// Shared types, defaults and pyramid dimension tables for the scanning-window sequencer.
package vj_sched_pkg;

  localparam int unsigned DEFAULT_LEVELS       = 9;
  localparam int unsigned DEFAULT_WINDOW_SIZE  = 24;
  localparam int unsigned DEFAULT_INT_IMG_WAIT = 10;
  localparam int unsigned DEFAULT_MAX_INFLIGHT = 64;

  localparam int unsigned IDX_W     = 16;
  localparam int unsigned LVL_W     = 4;
  localparam int unsigned LVL_SLOTS = 2 ** LVL_W;

  localparam logic [LVL_W-1:0] IMG_INDEX_IDLE = 4'd15;

  // Entry [0] is level 0 (full frame); each level is roughly 1/1.25 of the previous.
  localparam logic [DEFAULT_LEVELS-1:0][IDX_W-1:0] PYRAMID_WIDTHS = {
    16'd52, 16'd66, 16'd83, 16'd104, 16'd130, 16'd163, 16'd204, 16'd256, 16'd320
  };
  localparam logic [DEFAULT_LEVELS-1:0][IDX_W-1:0] PYRAMID_HEIGHTS = {
    16'd38, 16'd48, 16'd61, 16'd77, 16'd97, 16'd122, 16'd153, 16'd192, 16'd240
  };

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INT,
    SCAN,
    DRAIN,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [LVL_W-1:0] lvl;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } win_pos_t;

  // Last valid window start index along a dimension.
  function automatic logic [IDX_W-1:0] last_start(input logic [IDX_W-1:0] dim,
                                                  input int unsigned     ws);
    return IDX_W'(dim - IDX_W'(ws) - IDX_W'(1));
  endfunction

endpackage

// File: rtl/scan_index_gen.sv
// Level/row/col raster counter over all pyramid levels; advances one window per accept.
module scan_index_gen
  import vj_sched_pkg::*;
#(
  parameter int unsigned                           PYRAMID_LEVELS = DEFAULT_LEVELS,
  parameter int unsigned                           WINDOW_SIZE    = DEFAULT_WINDOW_SIZE,
  parameter logic [PYRAMID_LEVELS-1:0][IDX_W-1:0]  LVL_WIDTHS     = PYRAMID_WIDTHS,
  parameter logic [PYRAMID_LEVELS-1:0][IDX_W-1:0]  LVL_HEIGHTS    = PYRAMID_HEIGHTS
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     clear_i,
  input  logic     advance_i,
  output win_pos_t pos_o,
  output logic     last_o
);

  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(PYRAMID_LEVELS - 1);

  win_pos_t         pos_q;
  win_pos_t         pos_d;
  logic [IDX_W-1:0] col_max_tbl [LVL_SLOTS];
  logic [IDX_W-1:0] row_max_tbl [LVL_SLOTS];
  logic [IDX_W-1:0] col_max;
  logic [IDX_W-1:0] row_max;
  logic             col_more;
  logic             row_more;
  logic             lvl_end;

  // Per-level last start indices, padded so the level register indexes the table directly.
  for (genvar g = 0; g < int'(LVL_SLOTS); g++) begin : g_tbl
    if (g < int'(PYRAMID_LEVELS)) begin : g_used
      assign col_max_tbl[g] = last_start(LVL_WIDTHS[g], WINDOW_SIZE);
      assign row_max_tbl[g] = last_start(LVL_HEIGHTS[g], WINDOW_SIZE);
    end else begin : g_unused
      assign col_max_tbl[g] = '0;
      assign row_max_tbl[g] = '0;
    end
  end

  assign col_max  = col_max_tbl[pos_q.lvl];
  assign row_max  = row_max_tbl[pos_q.lvl];
  assign col_more = pos_q.col < col_max;
  assign row_more = pos_q.row < row_max;
  assign lvl_end  = pos_q.lvl == LVL_LAST;
  assign last_o   = lvl_end && !row_more && !col_more;

  always_comb begin
    pos_d = pos_q;
    if (clear_i) begin
      pos_d = '0;
    end else if (advance_i) begin
      if (col_more) begin
        pos_d.col = pos_q.col + IDX_W'(1);
      end else begin
        pos_d.col = '0;
        if (row_more) begin
          pos_d.row = pos_q.row + IDX_W'(1);
        end else begin
          pos_d.row = '0;
          // Wrap after the final window so the level never leaves the table.
          pos_d.lvl = lvl_end ? '0 : pos_q.lvl + LVL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/scan_win_sequencer.sv
// Frame sequencer: waits for integral-image settle, offers every window position, drains the
// classifier pipeline and pulses frame_done_o once all issued windows have retired.
module scan_win_sequencer
  import vj_sched_pkg::*;
#(
  parameter int unsigned                           PYRAMID_LEVELS = DEFAULT_LEVELS,
  parameter int unsigned                           WINDOW_SIZE    = DEFAULT_WINDOW_SIZE,
  parameter int unsigned                           INT_IMG_WAIT   = DEFAULT_INT_IMG_WAIT,
  parameter int unsigned                           MAX_INFLIGHT   = DEFAULT_MAX_INFLIGHT,
  parameter logic [PYRAMID_LEVELS-1:0][IDX_W-1:0]  LVL_WIDTHS     = PYRAMID_WIDTHS,
  parameter logic [PYRAMID_LEVELS-1:0][IDX_W-1:0]  LVL_HEIGHTS    = PYRAMID_HEIGHTS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             img_rdy_i,
  input  logic             abort_i,
  input  logic             win_ready_i,
  input  logic             result_valid_i,
  output logic             win_valid_o,
  output logic [LVL_W-1:0] img_index_o,
  output logic [IDX_W-1:0] row_index_o,
  output logic [IDX_W-1:0] col_index_o,
  output logic             last_win_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             overrun_o
);

  localparam int unsigned       WAIT_W    = $clog2(INT_IMG_WAIT + 1);
  localparam int unsigned       INFL_W    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INT_IMG_WAIT);
  localparam logic [INFL_W-1:0] INFL_MAX  = INFL_W'(MAX_INFLIGHT);

  sched_state_t      state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [INFL_W-1:0] inflight_q, inflight_d;
  logic              win_valid_q, win_valid_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;

  win_pos_t          pos;
  logic              pos_last;
  logic              in_scan;
  logic              accept;
  logic              retire;

  assign in_scan = state_q == SCAN;
  assign accept  = win_valid_q && win_ready_i;
  assign retire  = result_valid_i && (inflight_q != '0);

  scan_index_gen #(
    .PYRAMID_LEVELS (PYRAMID_LEVELS),
    .WINDOW_SIZE    (WINDOW_SIZE),
    .LVL_WIDTHS     (LVL_WIDTHS),
    .LVL_HEIGHTS    (LVL_HEIGHTS)
  ) u_index_gen (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (!in_scan),
    .advance_i (accept),
    .pos_o     (pos),
    .last_o    (pos_last)
  );

  // Next-state, counters and registered output values.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    inflight_d   = inflight_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    win_valid_d  = 1'b0;
    busy_d       = 1'b0;

    if (accept && !retire && (inflight_q != INFL_MAX)) begin
      inflight_d = inflight_q + INFL_W'(1);
    end else if (retire && !accept) begin
      inflight_d = inflight_q - INFL_W'(1);
    end

    if (img_rdy_i && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (img_rdy_i) begin
          state_d   = WAIT_INT;
          wait_d    = WAIT_W'(1);
          overrun_d = 1'b0;
        end
      end
      WAIT_INT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = SCAN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      SCAN: begin
        if (accept && pos_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Count after this cycle's retire, so the final result ends the drain immediately.
        if (inflight_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d    = IDLE;
      wait_d     = '0;
      inflight_d = '0;
    end

    frame_done_d = state_d == DONE;
    win_valid_d  = (state_d == SCAN) && (inflight_d < INFL_MAX);
    busy_d       = state_d != IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      inflight_q   <= '0;
      win_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      inflight_q   <= inflight_d;
      win_valid_q  <= win_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign win_valid_o  = win_valid_q;
  assign img_index_o  = in_scan ? pos.lvl : IMG_INDEX_IDLE;
  assign row_index_o  = pos.row;
  assign col_index_o  = pos.col;
  assign last_win_o   = in_scan && pos_last;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_scan_win_sequencer.sv
// Self-checking bench for scan_win_sequencer on a two-level 28x27 / 26x25 pyramid.
module tb_scan_win_sequencer;

  localparam int WS    = 24;
  localparam int WAITC = 10;
  localparam int MAXF  = 4;
  localparam int TB_W [2] = '{28, 26};
  localparam int TB_H [2] = '{27, 25};

  logic        clock = 1'b0;
  logic        reset;
  logic        img_rdy;
  logic        abort;
  logic        win_ready;
  logic        result_valid;
  logic        win_valid_o;
  logic [3:0]  img_index_o;
  logic [15:0] row_index_o;
  logic [15:0] col_index_o;
  logic        last_win_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        overrun_o;

  int compared   = 0;
  int mismatched = 0;
  int exp_l[$];
  int exp_r[$];
  int exp_c[$];
  int nwin;

  scan_win_sequencer #(
    .PYRAMID_LEVELS (2),
    .WINDOW_SIZE    (WS),
    .INT_IMG_WAIT   (WAITC),
    .MAX_INFLIGHT   (MAXF),
    .LVL_WIDTHS     ({16'd26, 16'd28}),
    .LVL_HEIGHTS    ({16'd25, 16'd27})
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .img_rdy_i      (img_rdy),
    .abort_i        (abort),
    .win_ready_i    (win_ready),
    .result_valid_i (result_valid),
    .win_valid_o    (win_valid_o),
    .img_index_o    (img_index_o),
    .row_index_o    (row_index_o),
    .col_index_o    (col_index_o),
    .last_win_o     (last_win_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .overrun_o      (overrun_o)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // rmode: 0 ready always, 1 ready toggles, 2 random. lat<=0 means random 1..6 retire latency.
  task automatic run_frame(input string nm, input int rmode, input int lat, input int ovr_at,
                           input bit rst_drain, input bit prev_ovr);
    int idx      = 0;
    int inflight = 0;
    int last_acc = -1;
    int done_n   = -1;
    int pend[$];
    int tgt;
    bit wv, rdy, rv, acc, fin;
    fin = 1'b0;
    for (int n = 0; n < 600 && !fin; n++) begin
      @(negedge clock);
      wv = win_valid_o;
      check({nm, "/win_valid"}, 32'(wv), 32'(n >= WAITC + 1 && idx < nwin && inflight < MAXF));
      check({nm, "/busy"}, 32'(busy_o), 32'(n >= 1 && (done_n < 0 || n <= done_n)));
      check({nm, "/frame_done"}, 32'(frame_done_o), 32'(done_n >= 0 && n == done_n));
      check({nm, "/overrun"}, 32'(overrun_o), 32'((n == 0) ? prev_ovr : (ovr_at > 0 && n > ovr_at)));
      if (wv && idx < nwin) begin
        check({nm, "/img_index"}, 32'(img_index_o), exp_l[idx]);
        check({nm, "/row_index"}, 32'(row_index_o), exp_r[idx]);
        check({nm, "/col_index"}, 32'(col_index_o), exp_c[idx]);
        check({nm, "/last_win"}, 32'(last_win_o), 32'(idx == nwin - 1));
      end else if (n < WAITC + 1 || idx == nwin) begin
        check({nm, "/img_idle"}, 32'(img_index_o), 15);
      end
      if (done_n >= 0 && n == done_n + 1) begin
        fin = 1'b1;
      end else begin
        if (rmode == 0) rdy = 1'b1;
        else if (rmode == 1) rdy = (n % 2) == 0;
        else rdy = 1'($urandom_range(0, 1));
        rv = 1'b0;
        if (pend.size() > 0 && pend[0] == n) begin
          rv = 1'b1;
          void'(pend.pop_front());
        end
        if (n == 3) rv = 1'b1;
        img_rdy      = (n == 0) || (n == ovr_at);
        win_ready    = rdy;
        result_valid = rv;
        acc = wv && rdy;
        if (rv && inflight > 0) inflight--;
        if (acc) begin
          inflight++;
          tgt = n + ((lat > 0) ? lat : int'($urandom_range(1, 6)));
          if (pend.size() > 0 && tgt <= pend[$]) tgt = pend[$] + 1;
          pend.push_back(tgt);
          idx++;
          if (idx == nwin) last_acc = n;
        end
        if (rv && idx == nwin && inflight == 0 && done_n < 0) done_n = n + 1;
        if (rst_drain && last_acc >= 0 && n == last_acc + 2) begin
          #2 reset = 1'b1;
          #1;
          check({nm, "/rst_busy"}, 32'(busy_o), 0);
          check({nm, "/rst_img"}, 32'(img_index_o), 15);
          check({nm, "/rst_valid"}, 32'(win_valid_o), 0);
          check({nm, "/rst_row"}, 32'(row_index_o), 0);
          @(negedge clock);
          reset = 1'b0;
          img_rdy = 1'b0;
          win_ready = 1'b0;
          result_valid = 1'b0;
          for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check({nm, "/rst_no_done"}, 32'(frame_done_o), 0);
            check({nm, "/rst_idle"}, 32'(busy_o), 0);
          end
          fin = 1'b1;
        end
      end
    end
    img_rdy      = 1'b0;
    win_ready    = 1'b0;
    result_valid = 1'b0;
    if (!rst_drain) begin
      check({nm, "/win_count"}, idx, nwin);
      check({nm, "/done_seen"}, 32'(done_n >= 0), 1);
      if (lat > 0) check({nm, "/done_latency"}, done_n - last_acc, lat + 1);
    end
  endtask

  initial begin : stim
    int cnt;
    int dn;
    reset = 1'b1;
    img_rdy = 1'b0;
    abort = 1'b0;
    win_ready = 1'b0;
    result_valid = 1'b0;
    for (int l = 0; l < 2; l++)
      for (int r = 0; r <= TB_H[l] - WS - 1; r++)
        for (int c = 0; c <= TB_W[l] - WS - 1; c++) begin
          exp_l.push_back(l);
          exp_r.push_back(r);
          exp_c.push_back(c);
        end
    nwin = exp_l.size();

    #1;
    check("rst/win_valid", 32'(win_valid_o), 0);
    check("rst/img_index", 32'(img_index_o), 15);
    check("rst/row_index", 32'(row_index_o), 0);
    check("rst/col_index", 32'(col_index_o), 0);
    check("rst/last_win", 32'(last_win_o), 0);
    check("rst/busy", 32'(busy_o), 0);
    check("rst/frame_done", 32'(frame_done_o), 0);
    check("rst/overrun", 32'(overrun_o), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Stray retires while idle must leave the in-flight count at zero.
    result_valid = 1'b1;
    repeat (2) @(negedge clock);
    result_valid = 1'b0;
    check("stray/busy", 32'(busy_o), 0);

    run_frame("f1_basic", 0, 3, -1, 1'b0, 1'b0);
    run_frame("f2_toggle", 1, 3, -1, 1'b0, 1'b0);
    run_frame("f3_overrun", 0, 3, 15, 1'b0, 1'b0);
    run_frame("f4_random", 2, 0, -1, 1'b0, 1'b1);

    // Results withheld: the in-flight bound stops issue after MAXF accepts.
    @(negedge clock);
    img_rdy = 1'b1;
    win_ready = 1'b1;
    @(negedge clock);
    img_rdy = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (win_valid_o) cnt++;
      @(negedge clock);
    end
    check("hold/accepts", cnt, MAXF);
    check("hold/win_valid", 32'(win_valid_o), 0);
    check("hold/busy", 32'(busy_o), 1);
    result_valid = 1'b1;
    @(negedge clock);
    result_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (win_valid_o) begin
        cnt++;
        check("hold/5th_row", 32'(row_index_o), exp_r[4]);
        check("hold/5th_col", 32'(col_index_o), exp_c[4]);
      end
      @(negedge clock);
    end
    check("hold/one_more", cnt, 1);
    result_valid = 1'b1;
    @(negedge clock);
    result_valid = 1'b0;
    check("abort/6th_valid", 32'(win_valid_o), 1);
    check("abort/6th_row", 32'(row_index_o), exp_r[5]);
    check("abort/6th_col", 32'(col_index_o), exp_c[5]);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    win_ready = 1'b0;
    check("abort/win_valid", 32'(win_valid_o), 0);
    check("abort/busy", 32'(busy_o), 0);
    check("abort/img_index", 32'(img_index_o), 15);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (frame_done_o) dn++;
    end
    check("abort/no_done", dn, 0);

    run_frame("f5_random", 2, 0, -1, 1'b0, 1'b0);
    run_frame("f6_random", 2, 0, -1, 1'b0, 1'b0);
    run_frame("f7_rst_drain", 0, 3, -1, 1'b1, 1'b0);
    run_frame("f8_after_rst", 1, 0, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
